// File: rtl/e_mdu_pkg.sv
// Shared op codes, FSM states and decode helpers for the E-stage multiply/divide unit.
// Define MDU_MADD_EN to decode the madd/maddu/msub/msubu accumulate ops.
package e_mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MADD  = 4'd7,
    MDU_MADDU = 4'd8,
    MDU_MSUB  = 4'd9,
    MDU_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic op_is_acc(logic [3:0] op);
    return (op == MDU_MADD) || (op == MDU_MADDU) ||
           (op == MDU_MSUB) || (op == MDU_MSUBU);
  endfunction

  function automatic logic op_is_div(logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Op codes of a disabled feature fall back to MDU_NONE and are never accepted.
  function automatic logic op_valid(logic [3:0] op);
    logic base;
    base = (op >= MDU_MULT) && (op <= MDU_MTLO);
`ifdef MDU_MADD_EN
    return base || op_is_acc(op);
`else
    return base;
`endif
  endfunction

  function automatic logic op_is_mul(logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || op_is_acc(op);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational datapath of the MDU: produces the full 64-bit {hi,lo} result for any op.
// Division works on magnitudes so INT_MIN / -1 wraps to INT_MIN without a special case.
module e_mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] acc;
  logic        sgn_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  always_comb begin
    prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u  = {32'b0, a} * {32'b0, b};
    acc     = {hi, lo};

    sgn_div = (op == MDU_DIV);
    a_mag   = (sgn_div && a[31]) ? -a : a;
    b_mag   = (sgn_div && b[31]) ? -b : b;
    q_mag   = (b_mag != 32'd0) ? a_mag / b_mag : 32'd0;
    r_mag   = (b_mag != 32'd0) ? a_mag % b_mag : 32'd0;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    quot    = (sgn_div && (a[31] ^ b[31])) ? -q_mag : q_mag;
    rem     = (sgn_div && a[31]) ? -r_mag : r_mag;

    div_zero = op_is_div(op) && (b == 32'd0);

    case (op)
      MDU_MULT:  res = prod_s;
      MDU_MULTU: res = prod_u;
      MDU_DIV,
      MDU_DIVU:  res = {rem, quot};
      MDU_MTHI:  res = {a, lo};
      MDU_MTLO:  res = {hi, a};
      MDU_MADD:  res = acc + prod_s;
      MDU_MADDU: res = acc + prod_u;
      MDU_MSUB:  res = acc - prod_s;
      MDU_MSUBU: res = acc - prod_u;
      default:   res = acc;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: HI/LO registers plus a countdown FSM that models op latency.
// Build with MDU_MADD_EN defined to accept the multiply-accumulate ops.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_dz_q, pend_dz_d;

  logic [63:0] calc_res;
  logic        calc_dz;
  logic        accept;

  e_mdu_calc u_calc (
    .op       (op),
    .a        (A),
    .b        (B),
    .hi       (hi_q),
    .lo       (lo_q),
    .res      (calc_res),
    .div_zero (calc_dz)
  );

  assign accept = start && (state_q == ST_IDLE) && op_valid(op);

  always_comb begin
    // NOTE: every variable gets its hold value first, so no branch can infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op_is_mul(op) || op_is_div(op)) begin
            state_d   = ST_BUSY;
            cnt_d     = op_is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_hi_d = calc_res[63:32];
            pend_lo_d = calc_res[31:0];
            pend_dz_d = calc_dz;
          end else begin
            hi_d = calc_res[63:32];
            lo_d = calc_res[31:0];
          end
        end
      end
      ST_BUSY: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed corner cases plus random ops against an arithmetic model.
// Honours MDU_MADD_EN the same way the design does.
module tb_e_mdu;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int          n_checks = 0;
  int          n_fails  = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  always #5 clk = ~clk;

  e_mdu dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: applies one op to m_hi/m_lo with plain 64-bit arithmetic, returns busy cycles.
  function automatic int model_exec(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] acc;
    logic [63:0] ps;
    logic [63:0] pu;
    acc = {m_hi, m_lo};
    ps  = 64'(longint'($signed(a)) * longint'($signed(b)));
    pu  = 64'(a) * 64'(b);
    case (o)
      4'd1: begin {m_hi, m_lo} = ps; return MULT_N; end
      4'd2: begin {m_hi, m_lo} = pu; return MULT_N; end
      4'd3: begin
        if (b != 32'd0) begin
          m_lo = 32'(longint'($signed(a)) / longint'($signed(b)));
          m_hi = 32'(longint'($signed(a)) % longint'($signed(b)));
        end
        return DIV_N;
      end
      4'd4: begin
        if (b != 32'd0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
        return DIV_N;
      end
      4'd5: begin m_hi = a; return 0; end
      4'd6: begin m_lo = a; return 0; end
`ifdef MDU_MADD_EN
      4'd7:  begin {m_hi, m_lo} = acc + ps; return MULT_N; end
      4'd8:  begin {m_hi, m_lo} = acc + pu; return MULT_N; end
      4'd9:  begin {m_hi, m_lo} = acc - ps; return MULT_N; end
      4'd10: begin {m_hi, m_lo} = acc - pu; return MULT_N; end
`endif
      default: return 0;
    endcase
  endfunction

  // Issues one op, checks busy every cycle and HI/LO before and after commit.
  // inject >= 0 pulses a second (to-be-ignored) mult in that busy cycle.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int inject);
    int          n;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;
    pre_hi = m_hi;
    pre_lo = m_lo;
    n = model_exec(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("busy_on op%0d cyc%0d", o, i), 32'(busy), 32'd1);
      if (i == n - 1) begin
        check($sformatf("hi_hold op%0d", o), HI, pre_hi);
        check($sformatf("lo_hold op%0d", o), LO, pre_lo);
      end
      if (i == inject) begin
        start = 1'b1; op = 4'd1; A = $urandom; B = $urandom;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check($sformatf("busy_off op%0d", o), 32'(busy), 32'd0);
    check($sformatf("hi op%0d", o), HI, m_hi);
    check($sformatf("lo op%0d", o), LO, m_lo);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int          r_inj;

    rst = 1'b1; start = 1'b0; op = 4'd0; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, -1);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFE, 32'd3, -1);
    check("multu_hi", HI, 32'h0000_0002);
    check("multu_lo", LO, 32'hFFFF_FFFA);

    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);
    run_op(4'd4, 32'd7, 32'd0, -1);
    check("divu0_hi", HI, 32'hFFFF_FFFF);
    check("divu0_lo", LO, 32'hFFFF_FFFD);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("divovf_lo", LO, 32'h8000_0000);
    check("divovf_hi", HI, 32'd0);

    run_op(4'd5, 32'h1234_5678, 32'd0, -1);
    check("mthi_hi", HI, 32'h1234_5678);
    run_op(4'd1, 32'd7, 32'd9, 2);
    check("ignored_start_lo", LO, 32'd63);
    run_op(4'd1, 32'd11, 32'd13, MULT_N - 1);
    run_op(4'd0, 32'hDEAD_BEEF, 32'd1, -1);

    // Reset in the third busy cycle aborts the mult for good.
    @(negedge clk);
    start = 1'b1; op = 4'd1; A = 32'd5; B = 32'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("rst_mid_busy", 32'(busy), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check("rst_mid_busy_off", 32'(busy), 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    check("rst_mid_lo", LO, 32'd0);
    repeat (8) @(negedge clk);
    check("rst_no_commit_hi", HI, 32'd0);
    check("rst_no_commit_lo", LO, 32'd0);
    check("rst_no_commit_busy", 32'(busy), 32'd0);

    run_op(4'd5, 32'd0, 32'd0, -1);
    run_op(4'd6, 32'hFFFF_FFFF, 32'd0, -1);
    run_op(4'd8, 32'd1, 32'd1, -1);
`ifdef MDU_MADD_EN
    check("maddu_hi", HI, 32'd1);
    check("maddu_lo", LO, 32'd0);
`else
    check("maddu_off_hi", HI, 32'd0);
    check("maddu_off_lo", LO, 32'hFFFF_FFFF);
`endif

    for (int k = 0; k < 60; k++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = 32'd0;
        1:       r_b = 32'($signed($urandom_range(0, 4)) - 2);
        default: r_b = $urandom;
      endcase
      r_inj = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_op(r_op, r_a, r_b, r_inj);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
